// File: rtl/pio_change_fifo.sv
// rtl/pio_change_fifo.sv - timestamped change-capture FIFO for the HPS PIO output word
module pio_change_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pio_in,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         ENTRY_W   = DATA_WIDTH + TS_WIDTH;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [DATA_WIDTH-1:0] prev;
    logic [TS_WIDTH-1:0]   ts;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [4:0]            count;
    logic [4:0]            count_next;
    logic                  overflow;
    logic                  enable;
    logic                  irq_en;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ENTRY_W-1:0]    head;

    logic change;
    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic full;
    logic empty;
    logic wr_access;
    logic ctrl_wr;
    logic status_wr;
    logic flush;
    logic ovf_set;
    logic ovf_clr;
    logic unused_wdata;

    assign unused_wdata = ^{writedata[31:9], writedata[7:3]};

    assign wr_access = chipselect && !write_n;
    assign ctrl_wr   = wr_access && (address == ADDR_CTRL);
    assign status_wr = wr_access && (address == ADDR_STATUS);
    assign flush     = ctrl_wr && writedata[1];

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // The PIO has no write strobe: any difference from last cycle's word is an event.
    assign change   = (pio_in != prev);
    assign push_req = change && enable;
    assign pop_req  = chipselect && read && (address == ADDR_DATA) && !empty;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle;
    // a flush in the same cycle discards both.
    assign do_push = push_req && !flush && (!full || pop_req);
    assign do_pop  = pop_req && !flush;
    assign ovf_set = push_req && full && !pop_req && !flush;
    assign ovf_clr = status_wr && writedata[8];

    assign count_next = flush ? 5'd0 : (count + {4'b0, do_push} - {4'b0, do_pop});

    assign head = mem[rd_ptr];

    // Control/status state, pointers, timestamp and the registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '1;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b1;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            prev  <= pio_in;
            ts    <= ts + 1'b1;
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (ctrl_wr) begin
                enable <= writedata[0];
                irq_en <= writedata[2];
            end
            irq <= irq_en && (count_next != '0);
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {pio_in, ts};
    end

    // Zero-wait-state register read mux; the DATA view never bypasses a same-cycle push.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: begin
                if (!empty) begin
                    readdata[DATA_WIDTH-1:0]                 = head[ENTRY_W-1:TS_WIDTH];
                    readdata[DATA_WIDTH+TS_WIDTH-1:DATA_WIDTH] = head[TS_WIDTH-1:0];
                    readdata[31]                             = 1'b1;
                end
            end
            ADDR_STATUS: begin
                readdata[4:0] = count;
                readdata[8]   = overflow;
                readdata[9]   = empty;
                readdata[10]  = full;
            end
            ADDR_CTRL: begin
                readdata[0] = enable;
                readdata[2] = irq_en;
            end
            default: readdata = '0;
        endcase
    end

endmodule
